music_player_ctrl: RTL
======================

# music_player_ctrl

Transport controller for the speaker datapath. It sits between the beat PWM generator and the tone lookup table and replaces the free-running beat counter. It turns play/pause/stop commands and the beat square wave into a beat index, a song select and a tone-enable. It supports two songs of parameterised length, with one-shot or loop playback.

## Interface
- LEN0, 8'd128: beats in song 0, legal range 1..255; last index is LEN0-1.
- LEN1, 8'd64: beats in song 1, legal range 1..255; last index is LEN1-1.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- beat_pwm  in  1  beat square wave from the beat PWM generator, same clock domain.
- play  in  1  one-cycle command pulse (debounced upstream).
- pause  in  1  one-cycle command pulse.
- stop  in  1  one-cycle command pulse.
- song_sel  in  1  song requested at the next start.
- loop_en  in  1  level; 1 means wrap at the end of the song instead of finishing.
- ibeat  out  8  beat index into the tone table.
- song  out  1  song currently latched for playback.
- tone_en  out  1  1 only in PLAY; downstream gates tone frequency to silence when 0.
- state  out  2  IDLE=0, PLAY=1, PAUSE=2, DONE=3.
- done  out  1  one-cycle pulse at each end of song, in both loop and one-shot.

## Operation
- Edge detector: register prev holds beat_pwm from the previous cycle; beat = beat_pwm & ~prev. prev runs in every state.
- LEN = LEN1 when song=1, LEN0 when song=0. last = (ibeat == LEN-1).
- Command priority in every state: stop > pause > play > beat.
- IDLE:
  - ibeat=0, tone_en=0.
  - On play: song<=song_sel, ibeat<=0, go to PLAY.
  - pause and beat are ignored.
- PLAY:
  - On stop: go to IDLE, ibeat<=0.
  - On pause: go to PAUSE, ibeat held. A beat in the same cycle is dropped.
  - On play: no effect. song_sel is not re-sampled.
  - On beat with !last: ibeat<=ibeat+1.
  - On beat with last and loop_en=1: ibeat<=0, done<=1, stay in PLAY.
  - On beat with last and loop_en=0: go to DONE, ibeat held at LEN-1, done<=1.
- PAUSE:
  - ibeat held, tone_en=0.
  - On play: go to PLAY and continue from the held ibeat; song is unchanged.
  - On stop: go to IDLE, ibeat<=0.
  - Beats are ignored.
- DONE:
  - tone_en=0, ibeat=LEN-1.
  - On play: restart with song<=song_sel, ibeat<=0, go to PLAY.
  - On stop: go to IDLE, ibeat<=0.
- loop_en is sampled only at the last-beat decision. It may change at any time.
- Arithmetic: ibeat is 8 bits. It is never incremented past LEN-1, so the 8-bit counter never wraps.
- tone_en = (state == PLAY), decoded from the state register; it carries no extra register delay.

## Timing
- Reset values on the cycle after reset is sampled high:
  - state=IDLE, ibeat=0, song=0, tone_en=0, done=0.
  - prev=1. This prevents a spurious beat if beat_pwm is high when reset is released.
- Reset asserted mid-playback overrides all commands and beats in that cycle.
- Command latency:
  - A command sampled at edge N shows on state, ibeat and song after edge N.
  - tone_en changes in the same cycle as state.
- Beat latency:
  - beat_pwm first sampled high at edge N gives an ibeat update visible after edge N.
  - Exactly one advance per beat_pwm rising edge, independent of high-time length.
- Entering PLAY does not advance ibeat. The first advance happens on the next beat_pwm rising edge after entry.
- done:
  - High for exactly the one cycle after the last-beat edge.
  - Never asserted by stop or reset.
- LEN=1: every beat in PLAY is a last beat. Loop mode pulses done on every beat with ibeat fixed at 0.

## Test plan
- Reset with beat_pwm=1, then drop and raise beat_pwm while IDLE: state=0, ibeat=0, tone_en=0, done never pulses.
- song_sel=1, LEN1=4, loop_en=0, play, then 4 beat edges:
  - ibeat goes 0,1,2,3.
  - On the 4th edge: state=3, ibeat=3, done high for 1 cycle, tone_en=0.
  - Then play: ibeat=0, state=1.
- loop_en=1, song 1, LEN1=4, 9 beat edges: ibeat sequence 1,2,3,0,1,2,3,0,1, with done pulses after edges 4 and 8 only.
- In PLAY at ibeat=5:
  - pause in the same cycle as a beat edge: state=2, ibeat=5.
  - Two more beat edges: ibeat stays 5.
  - play: state=1, ibeat=5; the next edge gives ibeat=6.
- play, pause and stop together in PLAY: state=0, ibeat=0. Then toggle song_sel to 1 during PLAY: song stays 0 until the next start from IDLE or DONE.
- Reset asserted in PAUSE with ibeat=7: next cycle state=0, ibeat=0, song=0, done=0.

Source files
------------

// File: rtl/music_player_ctrl.sv
// Transport controller: turns play/pause/stop commands and the beat square wave
// into a beat index, a latched song select and a tone enable for two songs.
module music_player_ctrl #(
   parameter logic [7:0] LEN0 = 8'd128,
   parameter logic [7:0] LEN1 = 8'd64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       beat_pwm,
   input  logic       play,
   input  logic       pause,
   input  logic       stop,
   input  logic       song_sel,
   input  logic       loop_en,
   output logic [7:0] ibeat,
   output logic       song,
   output logic       tone_en,
   output logic [1:0] state,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLAY  = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] ibeat_q, ibeat_d;
   logic       song_q, song_d;
   logic       done_q, done_d;
   logic       prev_q, prev_d;

   logic       beat_s;
   logic [7:0] len_s;
   logic       last_s;

   // State register; prev resets high so a held-high beat_pwm is not seen as an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ibeat_q <= 8'd0;
         song_q  <= 1'b0;
         done_q  <= 1'b0;
         prev_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         ibeat_q <= ibeat_d;
         song_q  <= song_d;
         done_q  <= done_d;
         prev_q  <= prev_d;
      end
   end

   // Next-state logic with command priority stop > pause > play > beat.
   always_comb begin
      state_d = state_q;
      ibeat_d = ibeat_q;
      song_d  = song_q;
      done_d  = 1'b0;
      prev_d  = beat_pwm;
      beat_s  = beat_pwm & ~prev_q;
      len_s   = song_q ? LEN1 : LEN0;
      last_s  = (ibeat_q == (len_s - 8'd1));

      case (state_q)
         S_IDLE: begin
            ibeat_d = 8'd0;
            if (stop) begin
               state_d = S_IDLE;
            end else if (play) begin
               song_d  = song_sel;
               state_d = S_PLAY;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PLAY: begin
            if (stop) begin
               state_d = S_IDLE;
               ibeat_d = 8'd0;
            end else if (pause) begin
               state_d = S_PAUSE;
            end else if (beat_s) begin
               if (!last_s) begin
                  ibeat_d = ibeat_q + 8'd1;
               end else if (loop_en) begin
                  ibeat_d = 8'd0;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end else begin
               state_d = S_PLAY;
            end
         end
         S_PAUSE: begin
            if (stop) begin
               state_d = S_IDLE;
               ibeat_d = 8'd0;
            end else if (pause) begin
               state_d = S_PAUSE;
            end else if (play) begin
               state_d = S_PLAY;
            end else begin
               state_d = S_PAUSE;
            end
         end
         S_DONE: begin
            if (stop) begin
               state_d = S_IDLE;
               ibeat_d = 8'd0;
            end else if (play) begin
               song_d  = song_sel;
               ibeat_d = 8'd0;
               state_d = S_PLAY;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            ibeat_d = 8'd0;
         end
      endcase
   end

   assign ibeat   = ibeat_q;
   assign song    = song_q;
   assign done    = done_q;
   assign state   = state_q;
   assign tone_en = (state_q == S_PLAY);

endmodule
